// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - start/done handshake and result bus of the shift-add multiplier
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               overflow;

  modport master (
    output start, a, b,
    input  ready, busy, done, product, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product, overflow
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative unsigned WIDTH x WIDTH multiplier, one multiplier bit per cycle
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_shift_add_multiplier_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               overflow_q, overflow_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] acc_next;

  // Adder stage: acc_hi + (selected multiplicand), cin = 0; cout becomes the new MSB.
  always_comb begin
    addend          = acc_q[0] ? mcand_q : '0;
    {cout, sum}     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next        = {cout, sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          mcand_d = bus.a;
          acc_d   = {{WIDTH{1'b0}}, bus.b};
          count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = acc_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d    = S_DONE;
          product_d  = acc_next;
          overflow_d = |acc_next[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.done     = (state_q == S_DONE);
  assign bus.busy     = (state_q == S_RUN);
  assign bus.ready    = (state_q != S_RUN);
  assign bus.product  = product_q;
  assign bus.overflow = overflow_q;
endmodule
